// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/response
// channel and the decode-side valid/ready handshake.
// master: the fetch unit itself; slave: memory/decode/execute environment.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        misalign_fault;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data,
           dec_ready,
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, misalign_fault
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data,
           dec_ready,
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, misalign_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing, credit-limited in-order memory
// requests, instruction buffer towards decode, redirect flush with discard of
// stale in-flight responses.
// Optional feature macro FETCH_ALIGN_CHECK_EN: a misaligned redirect target
// enters a sticky fault state instead of being silently word-aligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic         clk,
  input logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  cnt_t        out_q, out_d;    // requests accepted whose responses are still wanted
  cnt_t        drop_q, drop_d;  // in-flight responses belonging to a flushed path
  cnt_t        fifo_cnt_q;
  ptr_t        fifo_wr_q, fifo_rd_q;
  ptr_t        pq_wr_q, pq_rd_q;
  logic [31:0] fifo_instr_q [DEPTH];
  logic [31:0] fifo_pc_q    [DEPTH];
  logic [31:0] pq_pc_q      [DEPTH];

  logic        redirect;
  logic        misalign;
  logic [31:0] redir_pc;
  logic        pop;
  cnt_t        credit_used;
  logic        req_valid;
  logic        req_fire;
  logic        resp_drop;
  logic        resp_keep;
  logic        resp_cnt;
  cnt_t        inflight;
  logic        flush;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
`endif

  // Redirect target handling and handshake/credit qualifiers.
  always_comb begin
`ifdef FETCH_ALIGN_CHECK_EN
    redir_pc = bus.redirect_pc;
    misalign = |bus.redirect_pc[1:0];
`else
    redir_pc = {bus.redirect_pc[31:2], 2'b00};
    misalign = 1'b0;
`endif
    redirect    = bus.redirect_valid && (state_q != StIdle);
    pop         = (fifo_cnt_q != '0) && bus.dec_ready;
    // An entry leaving to decode this cycle frees its credit immediately,
    // which is what allows one instruction per cycle with DEPTH=2.
    credit_used = fifo_cnt_q - cnt_t'(pop) + out_q;
    req_valid   = (state_q == StFetch) && !bus.redirect_valid && (credit_used < cnt_t'(DEPTH));
    req_fire    = req_valid && bus.imem_req_ready;
    resp_drop   = bus.imem_resp_valid && (drop_q != '0);
    resp_keep   = bus.imem_resp_valid && (drop_q == '0) && (out_q != '0);
    resp_cnt    = resp_drop || resp_keep;
    inflight    = out_q + drop_q + cnt_t'(req_fire) - cnt_t'(resp_cnt);
  end

  // Next-state logic for FSM, PC and request/drop counters.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    drop_d  = drop_q;
    flush   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    if (req_fire) begin
      pc_d  = pc_q + 32'd4;
      out_d = out_q + 1'b1;
    end
    if (resp_keep) out_d = out_d - 1'b1;
    if (resp_drop) drop_d = drop_q - 1'b1;

    unique case (state_q)
      StIdle:  state_d = StFetch;
      StDrain: if (drop_d == '0) state_d = StFetch;
      default: ;
    endcase

    if (redirect) begin
      flush   = 1'b1;
      pc_d    = redir_pc;
      out_d   = '0;
      drop_d  = inflight;
      state_d = (inflight != '0) ? StDrain : StFetch;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_d = misalign;
`endif
      if (misalign) state_d = StFault;
    end
  end

  // FSM, PC and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  // Buffer and pending-PC queue pointers; a redirect empties both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
    end else if (flush) begin
      fifo_cnt_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
    end else begin
      fifo_cnt_q <= fifo_cnt_q + cnt_t'(resp_keep) - cnt_t'(pop);
      if (resp_keep) fifo_wr_q <= fifo_wr_q + 1'b1;
      if (pop)       fifo_rd_q <= fifo_rd_q + 1'b1;
      if (req_fire)  pq_wr_q   <= pq_wr_q + 1'b1;
      if (resp_keep) pq_rd_q   <= pq_rd_q + 1'b1;
    end
  end

  // Storage: buffer entries pair each response with the PC it was fetched from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
        pq_pc_q[i]      <= '0;
      end
    end else begin
      if (req_fire) pq_pc_q[pq_wr_q] <= pc_q;
      if (resp_keep && !flush) begin
        fifo_instr_q[fifo_wr_q] <= bus.imem_resp_data;
        fifo_pc_q[fifo_wr_q]    <= pq_pc_q[pq_rd_q];
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.dec_valid      = (fifo_cnt_q != '0);
  assign bus.dec_instr      = fifo_instr_q[fifo_rd_q];
  assign bus.dec_pc         = fifo_pc_q[fifo_rd_q];
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.misalign_fault = fault_q;
`else
  assign bus.misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory with configurable
// latency and random acceptance, PC/instruction scoreboard on the decode side,
// a table of redirect scenarios plus hand-written reset/stall/backpressure runs.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] target;
    int          n;
    int          dec_pct;
    int          req_pct;
    int          lat;
    logic [31:0] first;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  bit          sb_on = 1'b1;
  int          lat_cfg = 1;
  int          req_pct = 100;
  int          cyc = 0;
  int          acc_cnt = 0;
  logic [31:0] acc_log[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  bit          prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Memory model and decode-side monitor: drive at negedge, sample 1 ns later.
  initial begin
    logic [31:0] e;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        bus.imem_resp_valid = 1'b0;
      end
      bus.imem_req_ready = (int'($urandom_range(99)) < req_pct);
      #1;
      if (rst_n) begin
        if (prev_pend && !bus.redirect_valid) begin
          check32("req_hold_valid", {31'b0, bus.imem_req_valid}, 32'd1);
          check32("req_hold_addr", bus.imem_req_addr, prev_addr);
        end
        prev_pend = bus.imem_req_valid && !bus.imem_req_ready;
        prev_addr = bus.imem_req_addr;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          pend_addr.push_back(bus.imem_req_addr);
          pend_due.push_back(cyc + lat_cfg);
          acc_cnt++;
          acc_log.push_back(bus.imem_req_addr);
        end
        if (sb_on && bus.dec_valid && bus.dec_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_delivery: got pc %h want none", bus.dec_pc);
          end else begin
            e = exp_q.pop_front();
            check32("dec_pc", bus.dec_pc, e);
            check32("dec_instr", bus.dec_instr, mem_word(e));
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
  endtask

  // One-cycle redirect pulse, called at a negedge; returns at the next negedge.
  task automatic do_redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  // Consume the expected stream with a random dec_ready duty, bounded in time.
  task automatic wait_drain(input string name, input int pct);
    for (int k = 0; k < 1000 && exp_q.size() != 0; k++) begin
      bus.dec_ready = (int'($urandom_range(99)) < pct);
      @(negedge clk);
    end
    bus.dec_ready = 1'b0;
    check32(name, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    vec_t vecs[5];
    int   n_vec;
    vecs[0] = '{target: 32'h0000_0100, n: 6, dec_pct: 100, req_pct: 100, lat: 3,
                first: 32'h0000_0100};
    vecs[1] = '{target: 32'h0000_0200, n: 8, dec_pct: 50, req_pct: 70, lat: 1,
                first: 32'h0000_0200};
    vecs[2] = '{target: 32'hFFFF_FFF8, n: 4, dec_pct: 100, req_pct: 100, lat: 1,
                first: 32'hFFFF_FFF8};
    vecs[3] = '{target: 32'h0000_1000, n: 10, dec_pct: 30, req_pct: 40, lat: 2,
                first: 32'h0000_1000};
    vecs[4] = '{target: 32'h0000_0102, n: 4, dec_pct: 100, req_pct: 100, lat: 1,
                first: 32'h0000_0100};
`ifdef FETCH_ALIGN_CHECK_EN
    n_vec = 4;
`else
    n_vec = 5;
`endif

    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check32("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    check32("rst_req_addr", bus.imem_req_addr, 32'h0);
    check32("rst_dec_valid", {31'b0, bus.dec_valid}, 32'd0);
    check32("rst_dec_instr", bus.dec_instr, 32'h0);
    check32("rst_dec_pc", bus.dec_pc, 32'h0);
    check32("rst_fault", {31'b0, bus.misalign_fault}, 32'd0);

    // Release: IDLE cycle, first request in cycle 2, one delivery per cycle from cycle 4.
    @(negedge clk);
    rst_n = 1'b1;
    bus.dec_ready = 1'b1;
    push_exp(32'h0, 8);
    #1;
    check32("idle_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
    @(negedge clk);
    #1;
    check32("first_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check32("first_req_addr", bus.imem_req_addr, 32'h0);
    @(negedge clk);
    #1;
    check32("no_bypass", {31'b0, bus.dec_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check32("stream_dec_valid", {31'b0, bus.dec_valid}, 32'd1);
    end
    @(negedge clk);
    bus.dec_ready = 1'b0;
    check32("stream_all_delivered", exp_q.size(), 32'd0);
    exp_q.delete();

    // Decode backpressure: two requests fill the buffer, then fetch stalls.
    @(negedge clk);
    lat_cfg = 1;
    req_pct = 100;
    push_exp(32'h0, 4);
    acc_cnt = 0;
    acc_log.delete();
    do_redirect(32'h0);
    repeat (10) @(negedge clk);
    #1;
    check32("bp_accepted", acc_cnt, 32'd2);
    check32("bp_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    check32("bp_dec_valid", {31'b0, bus.dec_valid}, 32'd1);
    check32("bp_head_pc", bus.dec_pc, 32'h0);
    @(negedge clk);
    wait_drain("bp_drain", 100);
    check32("bp_resume_addr", (acc_log.size() > 2) ? acc_log[2] : 32'hDEAD_BEEF, 32'h8);

    // Memory stalls requests: address held, nothing reaches decode.
    @(negedge clk);
    req_pct = 0;
    push_exp(32'h0, 2);
    do_redirect(32'h0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check32("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
      check32("stall_req_addr", bus.imem_req_addr, 32'h0);
      check32("stall_dec_valid", {31'b0, bus.dec_valid}, 32'd0);
    end
    @(negedge clk);
    req_pct = 100;
    wait_drain("stall_drain", 100);

    // Redirect table: prime the old path, redirect, expect only the new path.
    for (int v = 0; v < n_vec; v++) begin
      @(negedge clk);
      sb_on = 1'b0;
      lat_cfg = vecs[v].lat;
      req_pct = vecs[v].req_pct;
      bus.dec_ready = 1'b1;
      repeat (6) @(negedge clk);
      bus.dec_ready = 1'b0;
      sb_on = 1'b1;
      exp_q.delete();
      push_exp(vecs[v].first, vecs[v].n);
      do_redirect(vecs[v].target);
      wait_drain("vec_drain", vecs[v].dec_pct);
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect faults; an aligned redirect recovers.
    @(negedge clk);
    lat_cfg = 2;
    req_pct = 100;
    exp_q.delete();
    do_redirect(32'h0000_0102);
    #1;
    check32("fault_set", {31'b0, bus.misalign_fault}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check32("fault_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
      check32("fault_no_dec", {31'b0, bus.dec_valid}, 32'd0);
      check32("fault_sticky", {31'b0, bus.misalign_fault}, 32'd1);
    end
    @(negedge clk);
    push_exp(32'h0000_0200, 3);
    do_redirect(32'h0000_0200);
    wait_drain("fault_recover", 100);
    check32("fault_cleared", {31'b0, bus.misalign_fault}, 32'd0);
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
